// File: rtl/pipe_stage_ctrl.sv
// Pipeline-register controller: owns PC and the IF/ID .. MEM/WB stage registers,
// applying per-stage holds, bubble insertion and taken-branch flushes.
module pipe_stage_ctrl #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0,
  parameter logic [XLEN-1:0]     NOP      = XLEN'(32'h0000_0013)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [4:0]      halt,
  input  logic            taken_branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] id_ex_instr,
  output logic [XLEN-1:0] ex_mem_instr,
  output logic [XLEN-1:0] mem_wb_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] ex_mem_pc,
  output logic [XLEN-1:0] mem_wb_pc,
  output logic            if_id_valid,
  output logic            id_ex_valid,
  output logic            ex_mem_valid,
  output logic            mem_wb_valid,
  output logic [15:0]     stall_count,
  output logic [15:0]     flush_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } stage_t;

  localparam stage_t BUBBLE = '{instr: NOP, pc: '0, valid: 1'b0};

  // Index matches the halt bit: 3=IF/ID, 2=ID/EX, 1=EX/MEM, 0=MEM/WB.
  stage_t            stage_q [4];
  stage_t            stage_d [4];
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic [4:0]        h;
  logic              flush;
  stage_t            fetch;

  // Effective holds, flush decision and next value of every pipeline register.
  always_comb begin
    h[0] = halt[0];
    h[1] = |halt[1:0];
    h[2] = |halt[2:0];
    h[3] = |halt[3:0];
    h[4] = |halt[4:0];

    flush = taken_branch & ~h[2];
    fetch = '{instr: if_instr, pc: pc_q, valid: 1'b1};

    pc_d = pc_q;
    if (flush) begin
      pc_d = branch_target;
    end else if (!h[4]) begin
      pc_d = pc_q + XLEN'(4);
    end

    stage_d[3] = stage_q[3];
    if (!h[3]) stage_d[3] = h[4] ? BUBBLE : fetch;

    stage_d[2] = stage_q[2];
    if (!h[2]) stage_d[2] = h[3] ? BUBBLE : stage_q[3];

    stage_d[1] = stage_q[1];
    if (!h[1]) stage_d[1] = h[2] ? BUBBLE : stage_q[2];

    stage_d[0] = stage_q[0];
    if (!h[0]) stage_d[0] = h[1] ? BUBBLE : stage_q[1];

    // A flush kills the two wrong-path instructions behind the branch.
    if (flush) begin
      stage_d[3] = BUBBLE;
      stage_d[2] = BUBBLE;
    end

    stall_d = stall_q;
    if ((halt != 5'd0) && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);

    flush_d = flush_q;
    if (flush && (flush_q != CNT_MAX)) flush_d = flush_q + CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q    <= RESET_PC;
      stall_q <= '0;
      flush_q <= '0;
      for (int i = 0; i < 4; i++) stage_q[i] <= BUBBLE;
    end else begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      for (int i = 0; i < 4; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign pc           = pc_q;
  assign if_id_instr  = stage_q[3].instr;
  assign id_ex_instr  = stage_q[2].instr;
  assign ex_mem_instr = stage_q[1].instr;
  assign mem_wb_instr = stage_q[0].instr;
  assign if_id_pc     = stage_q[3].pc;
  assign id_ex_pc     = stage_q[2].pc;
  assign ex_mem_pc    = stage_q[1].pc;
  assign mem_wb_pc    = stage_q[0].pc;
  assign if_id_valid  = stage_q[3].valid;
  assign id_ex_valid  = stage_q[2].valid;
  assign ex_mem_valid = stage_q[1].valid;
  assign mem_wb_valid = stage_q[0].valid;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Pipeline-register controller for the five-stage RV32 core. It owns the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB instruction/PC/valid registers. It consumes the 5-bit `halt` vector and `taken_branch` produced by the hazard logic, and applies holds, bubble insertion and branch flushes. Every downstream stage sees a consistent, registered instruction stream.

## Interface
- `XLEN`, 32, datapath width (from `define.v`).
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `i_clk`  in  1  single clock; all state updates on rising edge.
- `i_rst`  in  1  reset; asynchronous and active-low.
- `halt`  in  5  hold request per stage: [4]=PC, [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB.
- `taken_branch`  in  1  branch/jump resolved taken in EX.
- `branch_target`  in  XLEN  redirect address, valid with `taken_branch`.
- `if_instr`  in  XLEN  instruction fetched at current `pc`.
- `pc`  out  XLEN  fetch address.
- `if_id_instr`, `id_ex_instr`, `ex_mem_instr`, `mem_wb_instr`  out  XLEN  stage instructions.
- `if_id_pc`, `id_ex_pc`, `ex_mem_pc`, `mem_wb_pc`  out  XLEN  stage PCs.
- `if_id_valid`, `id_ex_valid`, `ex_mem_valid`, `mem_wb_valid`  out  1  stage holds a real instruction.
- `stall_count`  out  16  saturating count of cycles with `halt != 0`.
- `flush_count`  out  16  saturating count of honored flushes.

## Operation
- Effective hold, stage i: `h[i] = |halt[i:0]`. A held downstream stage forces every upstream stage to hold. The held region is therefore always contiguous from PC, and no instruction is ever overwritten. Any 5-bit pattern is legal.
- Stage update when not held:
  - PC advances to `pc+4`.
  - IF/ID loads {`if_instr`, `pc`, 1}.
  - Each later stage loads its upstream stage's instr/pc/valid.
- Stage i not held while upstream stage i+1 is held: stage i loads a bubble, {`NOP`, 0, 0}.
- A held stage keeps all of its fields.
- Flush is honored only when `taken_branch && !h[2]`:
  - PC loads `branch_target`.
  - IF/ID and ID/EX load bubbles; flush overrides `h[4:3]`.
  - EX/MEM and MEM/WB follow the normal rules, so EX/MEM receives the branch instruction.
- `taken_branch` with `h[2]=1` is ignored: no redirect, `flush_count` unchanged. The branch remains in ID/EX and is re-resolved.
- `stall_count` increments when `halt != 0`. `flush_count` increments on each honored flush. Both saturate at 16'hFFFF.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous assert, any time, including mid-stall or mid-flush):
  - `pc = RESET_PC`.
  - All stage instrs = `NOP`; all stage PCs = 0; all valids = 0.
  - Both counters = 0.
- First fetch after reset release: `pc = RESET_PC`. IF/ID is valid one cycle later.
- Latency: an instruction fetched at edge n appears in IF/ID at n+1, ID/EX at n+2, EX/MEM at n+3, MEM/WB at n+4. Each cycle of `h[i]` covering it adds one cycle.
- `halt` and `taken_branch` are sampled every edge and apply to that edge only; there is no internal stall state.
- Redirect: `pc = branch_target` one edge after the honored flush. The target instruction reaches IF/ID on the following edge, giving a 2-bubble branch penalty.
- `pc+4` wraps modulo 2^XLEN with no error.

## Test plan
- Reset: drive `i_rst=0` mid-stream -> immediately `pc=0`, all instrs 32'h13, all valids 0, counters 0; release -> `pc` steps 0, 4, 8.
- Free run: instrs A, B, C, D fetched from `pc` 0 -> after 4 edges `mem_wb_instr=A`, `mem_wb_pc=0`, `mem_wb_valid=1`, `pc=16`.
- Load-use pattern: `halt=5'b11100` for 1 cycle with ID/EX=C, EX/MEM=B -> `pc`, IF/ID and ID/EX unchanged; EX/MEM = {NOP, 0, valid 0}; MEM/WB=B; `stall_count=1`.
- Sparse hold: `halt=5'b00010` -> PC through EX/MEM all hold; MEM/WB gets a bubble; next cycle with `halt=0` the stream resumes with no instruction lost.
- Flush: `taken_branch=1`, `branch_target=32'h100`, `halt=0`, ID/EX=C -> `pc=0x100`; IF/ID and ID/EX are bubbles; `ex_mem_instr=C`; `flush_count=1`. Repeating with `halt=5'b11100` -> no redirect, `flush_count` stays 1.
- Saturation: hold `halt=5'b00001` for 70000 cycles -> all stages frozen; `stall_count=16'hFFFF`, no wrap.
